// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read data RAM between an instruction-fetch
// read port and a load/store port. Each access runs IDLE -> ACCESS -> [RMW_WR] -> DONE.
// Sub-word stores are done as a read-modify-write.
// Build option: define ARB_RR_EN to grant round-robin on IF/MEM contention
// (default: MEM has fixed priority over IF).
module mem_arbiter #(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ack,
    input  logic          mem_re,
    input  logic          mem_we,
    input  logic [31:0]   mem_addr,
    input  logic [3:0]    mem_sel,
    input  logic [31:0]   mem_wdata,
    output logic [31:0]   mem_rdata,
    output logic          mem_ack,
    output logic          stall_req,
    output logic          ram_ce,
    output logic          ram_re,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RMW_WR = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic          w_mem_pend;
    logic          w_grant_any;
    logic          w_grant_mem;
    logic          w_partial;

    logic          r_owner_mem;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_sel;
    logic [31:0]   r_wdata;
    logic          r_wr;
    logic [31:0]   r_word;
    logic          r_if_ack;
    logic          r_mem_ack;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_mem_rdata;

    // Byte-lane merge: lane i comes from new_w when sel[i] is set, else from old_w.
    function automatic logic [31:0] merge_bytes(input logic [3:0]  sel,
                                                input logic [31:0] new_w,
                                                input logic [31:0] old_w);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Byte-offset and upper address bits are deliberately ignored.
    logic w_unused_bits;
    assign w_unused_bits = ^{if_addr[1:0], if_addr[31:AW+2], mem_addr[1:0], mem_addr[31:AW+2]};

    assign w_mem_pend  = mem_re | mem_we;
    assign w_grant_any = w_mem_pend | if_req;
    assign w_partial   = (r_sel != 4'hF) && (r_sel != 4'h0);

`ifdef ARB_RR_EN
    logic r_rr_mem_first;

    // Round-robin pointer: after each grant, favour the other requester next time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_mem_first <= 1'b1;
        end else if ((r_state == S_IDLE) && w_grant_any) begin
            r_rr_mem_first <= ~w_grant_mem;
        end else begin
            r_rr_mem_first <= r_rr_mem_first;
        end
    end

    // Grant selection: pointer breaks IF/MEM ties, a lone requester always wins.
    always_comb begin
        w_grant_mem = 1'b0;
        if (w_mem_pend && if_req) begin
            w_grant_mem = r_rr_mem_first;
        end else begin
            w_grant_mem = w_mem_pend;
        end
    end
`else
    // Grant selection: load/store always beats instruction fetch.
    always_comb begin
        w_grant_mem = w_mem_pend;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_state_next = S_ACCESS;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (r_wr && w_partial) begin
                    w_state_next = S_RMW_WR;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_RMW_WR: w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: RAM strobes, address and write data per state.
    always_comb begin
        ram_ce    = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 32'h0000_0000;
        case (r_state)
            S_ACCESS: begin
                ram_ce   = 1'b1;
                ram_addr = r_addr;
                if (!r_wr) begin
                    ram_re = 1'b1;
                end else if (r_sel == 4'hF) begin
                    ram_we    = 1'b1;
                    ram_wdata = r_wdata;
                end else if (r_sel != 4'h0) begin
                    ram_re = 1'b1;
                end else begin
                    ram_re = 1'b0;
                end
            end
            S_RMW_WR: begin
                ram_ce    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_addr;
                ram_wdata = merge_bytes(r_sel, r_wdata, r_word);
            end
            default: begin
                ram_ce = 1'b0;
            end
        endcase
    end

    // Latch the winning request in IDLE; capture the old word for read-modify-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner_mem <= 1'b0;
            r_addr      <= '0;
            r_sel       <= 4'h0;
            r_wdata     <= 32'h0000_0000;
            r_wr        <= 1'b0;
            r_word      <= 32'h0000_0000;
        end else if ((r_state == S_IDLE) && w_grant_any) begin
            r_owner_mem <= w_grant_mem;
            if (w_grant_mem) begin
                r_addr  <= mem_addr[AW+1:2];
                r_sel   <= mem_sel;
                r_wdata <= mem_wdata;
                r_wr    <= mem_we;
            end else begin
                r_addr  <= if_addr[AW+1:2];
                r_sel   <= 4'hF;
                r_wdata <= 32'h0000_0000;
                r_wr    <= 1'b0;
            end
        end else if ((r_state == S_ACCESS) && r_wr && w_partial) begin
            r_word <= ram_rdata;
        end else begin
            r_word <= r_word;
        end
    end

    // Acks pulse during DONE; read data is held until the same owner reads again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= 32'h0000_0000;
            r_mem_rdata <= 32'h0000_0000;
        end else begin
            r_if_ack  <= (w_state_next == S_DONE) && !r_owner_mem;
            r_mem_ack <= (w_state_next == S_DONE) && r_owner_mem;
            if ((r_state == S_ACCESS) && !r_wr) begin
                if (r_owner_mem) begin
                    r_mem_rdata <= ram_rdata;
                end else begin
                    r_if_rdata <= ram_rdata;
                end
            end else begin
                r_mem_rdata <= r_mem_rdata;
            end
        end
    end

    assign if_ack    = r_if_ack;
    assign mem_ack   = r_mem_ack;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign stall_req = (if_req & ~r_if_ack) | (w_mem_pend & ~r_mem_ack);

endmodule
